ofs_plat_avalon_mem_responder: RTL
==================================

# ofs_plat_avalon_mem_responder

Avalon-MM sink (responder) that terminates the request stream produced by an Avalon memory source or the end of a register pipeline. It is backed by a local RAM of 2^ADDR_WIDTH words. It accepts read and write bursts under the waitrequest protocol and returns read beats on readdatavalid and one write response per write burst. It carries user fields back on readresponseuser and writeresponseuser. It serves as the far-end model in unit benches and as a scratch memory behind platform shims.

## Interface
- ADDR_WIDTH, 10, word address width; RAM depth is 2^ADDR_WIDTH
- DATA_WIDTH, 64, data bits per beat; byteenable is DATA_WIDTH/8 bits
- BURST_CNT_WIDTH, 4, burstcount width; maximum legal burst is 2^(BURST_CNT_WIDTH-1) beats
- USER_WIDTH, 1, request user field width
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- waitrequest  out  1  stall; a command or beat is accepted on (read|write) && !waitrequest
- read, write  in  1  command strobes
- address  in  ADDR_WIDTH  word address (first beat only)
- burstcount  in  BURST_CNT_WIDTH  beats in burst (first beat only)
- writedata  in  DATA_WIDTH  write beat data
- byteenable  in  DATA_WIDTH/8  per-byte write mask
- user  in  USER_WIDTH  request user field (first beat only)
- readdata  out  DATA_WIDTH  read beat data
- readdatavalid  out  1  read beat valid
- response  out  2  read response code
- readresponseuser  out  USER_WIDTH  user field echoed on each read beat
- writeresponsevalid  out  1  one-cycle pulse per completed write burst
- writeresponse  out  2  write response code
- writeresponseuser  out  USER_WIDTH  user field echoed with write response

## Operation
- FSM states:
  - IDLE: waitrequest=0.
  - WR_BURST: waitrequest=0; counts remaining write beats.
  - RD_BURST: waitrequest=1; issues one RAM read per cycle.
- IDLE transitions:
  - Accepted write with burstcount=1 performs the RAM write and stays in IDLE.
  - Accepted write with burstcount>1 latches address, user and remaining count (burstcount-1), then enters WR_BURST.
  - Accepted read latches address, burstcount and user, then enters RD_BURST.
- WR_BURST: each accepted write beat writes RAM[addr] under byteenable and increments addr. The final beat returns the FSM to IDLE. read is ignored in this state.
- RD_BURST: issues burstcount reads at 1 per cycle with incrementing addr, then returns to IDLE.
- Address increments wrap modulo 2^ADDR_WIDTH.
- burstcount=0 is illegal. It is serviced as a 1-beat burst and its response is SLVERR (2'b10). All other responses are OKAY (2'b00).
- read and write asserted together in IDLE is illegal. The write is serviced and the read is dropped. A simulation-only assertion fires on this condition.
- RAM writes commit on the accepting edge, so a read accepted afterwards returns the new data (no hazard).
- Reset mid-burst: returns the FSM to IDLE and discards the remaining beats. No write response is issued for an aborted write burst. RAM contents are not reset.

## Timing
- Reset values: waitrequest=1 while reset is asserted, falling to 0 in the first cycle after deassertion. readdatavalid=0, writeresponsevalid=0, readdata=0, response=0, writeresponse=0, both user outputs 0.
- Read: command accepted at edge T. Beat k (0-based) is valid in cycle T+2+k (1-cycle registered RAM read plus output register). waitrequest is high for cycles T+1..T+N and low again at T+N+1.
- Back-to-back reads: a new read accepted at T+N+1 has its first beat at T+N+3. This leaves a single bubble cycle between bursts.
- Write: last beat accepted at edge T gives writeresponsevalid=1 for cycle T+1 only.
- Throughput: one write beat per cycle in WR_BURST.
- All outputs are registered.

## Configuration
- OFS_PLAT_AVALON_MEM_RESPONDER_STATS_EN
  - Defined: adds output ports rd_beat_count[31:0] and wr_beat_count[31:0]. These count delivered read beats and accepted write beats, are reset to 0, and wrap at 2^32.
  - Undefined: the ports and counters are absent.

## Structure
- Package ofs_plat_avalon_mem_responder_pkg holds:
  - enum t_responder_state {IDLE, WR_BURST, RD_BURST}
  - constants AVMM_RESP_OKAY=2'b00 and AVMM_RESP_SLVERR=2'b10
- Sub-module ofs_plat_avalon_mem_responder_ram: simple dual-port, DATA_WIDTH x 2^ADDR_WIDTH, byte-enable write port, 1-cycle registered read port.

## Test plan
- Write burst addr=0x10, burstcount=4, data 0xA0..0xA3, user=1 -> single writeresponsevalid the cycle after beat 4, writeresponse=0, writeresponseuser=1. Then read addr=0x10, len 4 -> readdata 0xA0..0xA3 in cycles T+2..T+5, readresponseuser=1, waitrequest high for T+1..T+4.
- Write addr=0x3FF, burstcount=2 (ADDR_WIDTH=10) -> data lands at 0x3FF and 0x000. Read-back confirms the wrap.
- Write 0xFFFF_FFFF_FFFF_FFFF, then byteenable=0x0F with 0 -> readback 0xFFFF_FFFF_0000_0000.
- Read with burstcount=0 -> exactly one beat with response=2'b10.
- Assert reset during beat 2 of a 4-beat read -> readdatavalid=0 from reset onward, waitrequest=1 during reset, no further beats. A fresh read after reset works normally.
- With STATS_EN: 4-beat write plus 4-beat read -> wr_beat_count=4, rd_beat_count=4.

Source files
------------

// File: rtl/ofs_plat_avalon_mem_responder_pkg.sv
// Shared types and response codes for the Avalon-MM responder.
package ofs_plat_avalon_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } t_responder_state;

    localparam int unsigned AVMM_RESP_WIDTH = 2;

    localparam logic [AVMM_RESP_WIDTH-1:0] AVMM_RESP_OKAY   = 2'b00;
    localparam logic [AVMM_RESP_WIDTH-1:0] AVMM_RESP_SLVERR = 2'b10;

    // A zero burstcount is serviced as one beat but flagged with SLVERR.
    function automatic logic [AVMM_RESP_WIDTH-1:0] burst_resp(input logic count_is_zero);
        return count_is_zero ? AVMM_RESP_SLVERR : AVMM_RESP_OKAY;
    endfunction

endpackage

// File: rtl/ofs_plat_avalon_mem_responder_ram.sv
// Simple dual-port RAM: byte-enable write port, 1-cycle registered read port.
module ofs_plat_avalon_mem_responder_ram #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_byteenable,
    input  logic                      rd_en,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (wr_byteenable[b]) begin
                    mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ofs_plat_avalon_mem_responder.sv
// Avalon-MM responder backed by a local RAM; serves read/write bursts.
// Optional beat counters: define OFS_PLAT_AVALON_MEM_RESPONDER_STATS_EN.
module ofs_plat_avalon_mem_responder
    import ofs_plat_avalon_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 10,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned BURST_CNT_WIDTH = 4,
    parameter int unsigned USER_WIDTH      = 1
) (
    input  logic                         clk,
    input  logic                         reset,

    output logic                         waitrequest,
    input  logic                         read,
    input  logic                         write,
    input  logic [ADDR_WIDTH-1:0]        address,
    input  logic [BURST_CNT_WIDTH-1:0]   burstcount,
    input  logic [DATA_WIDTH-1:0]        writedata,
    input  logic [DATA_WIDTH/8-1:0]      byteenable,
    input  logic [USER_WIDTH-1:0]        user,

    output logic [DATA_WIDTH-1:0]        readdata,
    output logic                         readdatavalid,
    output logic [AVMM_RESP_WIDTH-1:0]   response,
    output logic [USER_WIDTH-1:0]        readresponseuser,

    output logic                         writeresponsevalid,
    output logic [AVMM_RESP_WIDTH-1:0]   writeresponse,
    output logic [USER_WIDTH-1:0]        writeresponseuser
`ifdef OFS_PLAT_AVALON_MEM_RESPONDER_STATS_EN
    ,
    output logic [31:0]                  rd_beat_count,
    output logic [31:0]                  wr_beat_count
`endif
);

    t_responder_state state, state_n;

    // Burst tracking registers
    logic [ADDR_WIDTH-1:0]        wr_addr;
    logic [BURST_CNT_WIDTH-1:0]   wr_remain;
    logic [USER_WIDTH-1:0]        wr_user;
    logic [ADDR_WIDTH-1:0]        rd_addr;
    logic [BURST_CNT_WIDTH-1:0]   rd_remain;
    logic [USER_WIDTH-1:0]        rd_user;
    logic [AVMM_RESP_WIDTH-1:0]   rd_resp;

    // Read pipeline stage aligned with the RAM output register
    logic                         rd_pend;
    logic [AVMM_RESP_WIDTH-1:0]   rd_pend_resp;
    logic [USER_WIDTH-1:0]        rd_pend_user;

    // Combinational controls
    logic                         ram_wr_en_c;
    logic [ADDR_WIDTH-1:0]        ram_wr_addr_c;
    logic                         ram_rd_en_c;
    logic [ADDR_WIDTH-1:0]        ram_rd_addr_c;
    logic [DATA_WIDTH-1:0]        ram_rd_data;
    logic                         wr_start_c;
    logic                         wr_beat_c;
    logic                         wr_done_c;
    logic [AVMM_RESP_WIDTH-1:0]   wr_resp_c;
    logic [USER_WIDTH-1:0]        wr_user_c;
    logic                         rd_start_c;
    logic                         rd_step_c;
    logic                         bc_zero_c;

    assign bc_zero_c = (burstcount == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and per-cycle command decode
    always_comb begin
        state_n       = state;
        ram_wr_en_c   = 1'b0;
        ram_wr_addr_c = wr_addr;
        ram_rd_en_c   = 1'b0;
        ram_rd_addr_c = rd_addr;
        wr_start_c    = 1'b0;
        wr_beat_c     = 1'b0;
        wr_done_c     = 1'b0;
        wr_resp_c     = AVMM_RESP_OKAY;
        wr_user_c     = wr_user;
        rd_start_c    = 1'b0;
        rd_step_c     = 1'b0;

        case (state)
            IDLE: begin
                // Write wins over a simultaneous read; the read is dropped.
                if (write && !waitrequest) begin
                    ram_wr_en_c   = 1'b1;
                    ram_wr_addr_c = address;
                    if (burstcount > BURST_CNT_WIDTH'(1)) begin
                        wr_start_c = 1'b1;
                        state_n    = WR_BURST;
                    end else begin
                        wr_done_c = 1'b1;
                        wr_resp_c = burst_resp(bc_zero_c);
                        wr_user_c = user;
                    end
                end else if (read && !waitrequest) begin
                    // First beat is fetched on the accepting edge.
                    ram_rd_en_c   = 1'b1;
                    ram_rd_addr_c = address;
                    rd_start_c    = 1'b1;
                    state_n       = RD_BURST;
                end
            end

            WR_BURST: begin
                if (write && !waitrequest) begin
                    ram_wr_en_c = 1'b1;
                    wr_beat_c   = 1'b1;
                    if (wr_remain == BURST_CNT_WIDTH'(1)) begin
                        wr_done_c = 1'b1;
                        state_n   = IDLE;
                    end
                end
            end

            RD_BURST: begin
                if (rd_remain != '0) begin
                    ram_rd_en_c = 1'b1;
                    rd_step_c   = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Burst address/count bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_addr   <= '0;
            wr_remain <= '0;
            wr_user   <= '0;
            rd_addr   <= '0;
            rd_remain <= '0;
            rd_user   <= '0;
            rd_resp   <= AVMM_RESP_OKAY;
        end else begin
            if (wr_start_c) begin
                wr_addr   <= address + ADDR_WIDTH'(1);
                wr_remain <= burstcount - BURST_CNT_WIDTH'(1);
                wr_user   <= user;
            end else if (wr_beat_c) begin
                wr_addr   <= wr_addr + ADDR_WIDTH'(1);
                wr_remain <= wr_remain - BURST_CNT_WIDTH'(1);
            end

            if (rd_start_c) begin
                rd_addr   <= address + ADDR_WIDTH'(1);
                rd_remain <= bc_zero_c ? '0 : burstcount - BURST_CNT_WIDTH'(1);
                rd_user   <= user;
                rd_resp   <= burst_resp(bc_zero_c);
            end else if (rd_step_c) begin
                rd_addr   <= rd_addr + ADDR_WIDTH'(1);
                rd_remain <= rd_remain - BURST_CNT_WIDTH'(1);
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waitrequest        <= 1'b1;
            rd_pend            <= 1'b0;
            rd_pend_resp       <= AVMM_RESP_OKAY;
            rd_pend_user       <= '0;
            readdatavalid      <= 1'b0;
            readdata           <= '0;
            response           <= AVMM_RESP_OKAY;
            readresponseuser   <= '0;
            writeresponsevalid <= 1'b0;
            writeresponse      <= AVMM_RESP_OKAY;
            writeresponseuser  <= '0;
        end else begin
            waitrequest  <= (state_n == RD_BURST);

            rd_pend      <= ram_rd_en_c;
            rd_pend_resp <= rd_start_c ? burst_resp(bc_zero_c) : rd_resp;
            rd_pend_user <= rd_start_c ? user : rd_user;

            readdatavalid <= rd_pend;
            if (rd_pend) begin
                readdata         <= ram_rd_data;
                response         <= rd_pend_resp;
                readresponseuser <= rd_pend_user;
            end

            writeresponsevalid <= wr_done_c;
            if (wr_done_c) begin
                writeresponse     <= wr_resp_c;
                writeresponseuser <= wr_user_c;
            end
        end
    end

    ofs_plat_avalon_mem_responder_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) ram (
        .clk           (clk),
        .wr_en         (ram_wr_en_c),
        .wr_addr       (ram_wr_addr_c),
        .wr_data       (writedata),
        .wr_byteenable (byteenable),
        .rd_en         (ram_rd_en_c),
        .rd_addr       (ram_rd_addr_c),
        .rd_data       (ram_rd_data)
    );

`ifdef OFS_PLAT_AVALON_MEM_RESPONDER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_beat_count <= '0;
            wr_beat_count <= '0;
        end else begin
            rd_beat_count <= rd_beat_count + 32'(rd_pend);
            wr_beat_count <= wr_beat_count + 32'(ram_wr_en_c);
        end
    end
`endif

`ifndef SYNTHESIS
    a_no_rd_wr_collision: assert property (@(posedge clk) disable iff (reset)
        !(state == IDLE && !waitrequest && read && write))
        else $error("read and write asserted together in IDLE; read dropped");
`endif

endmodule
